// File: rtl/pcm_frame_scheduler_pkg.sv
// Shared types and helpers for the PCM frame scheduler.
//   PCM_W         width of one PCM sample
//   SEQ_W         width of the per-frame sequence number
//   state_t       scheduler FSM states
//   payload_off() byte offset, within a bank, of one payload byte
package pcm_frame_scheduler_pkg;

    localparam int unsigned PCM_W = 16;
    localparam int unsigned SEQ_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWrLo,
        StWrHi,
        StSlot,
        StSeqLo,
        StSeqHi,
        StHand
    } state_t;

    // Header, then a 2-byte sequence field, then channel-interleaved little-endian samples.
    function automatic int unsigned payload_off(input int unsigned hdr_bytes,
                                                input int unsigned channels,
                                                input int unsigned slot,
                                                input int unsigned ch,
                                                input int unsigned b);
        return hdr_bytes + 2 + 2 * channels * slot + 2 * ch + b;
    endfunction

endpackage

// File: rtl/pcm_frame_scheduler_if.sv
// Signal bundle between the scheduler and its surroundings.
//   pcm_stb, pcm_data      PCM sample set from the filters
//   eth_busy               transmitter busy
//   bram_wr_*              byte write port into the ping-pong BRAM
//   eth_start, eth_bank    frame handoff to the transmitter
//   frame_len              byte count of one frame
//   overrun_cnt            frames dropped because the transmitter was busy
//   sample_miss            sticky flag, a strobe arrived while the scheduler was busy
// modport master: the scheduler; modport slave: the environment.
interface pcm_frame_scheduler_if
    import pcm_frame_scheduler_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned ADDR_W   = 10
);

    logic                      pcm_stb;
    logic [PCM_W*CHANNELS-1:0] pcm_data;
    logic                      eth_busy;
    logic                      bram_wr_en;
    logic [ADDR_W-1:0]         bram_wr_addr;
    logic [7:0]                bram_wr_data;
    logic                      eth_start;
    logic                      eth_bank;
    logic [ADDR_W-1:0]         frame_len;
    logic [7:0]                overrun_cnt;
    logic                      sample_miss;

    modport master (
        input  pcm_stb, pcm_data, eth_busy,
        output bram_wr_en, bram_wr_addr, bram_wr_data, eth_start, eth_bank, frame_len,
               overrun_cnt, sample_miss
    );

    modport slave (
        output pcm_stb, pcm_data, eth_busy,
        input  bram_wr_en, bram_wr_addr, bram_wr_data, eth_start, eth_bank, frame_len,
               overrun_cnt, sample_miss
    );

endinterface

// File: rtl/pcm_snapshot.sv
// Holds one PCM sample set and reads it back a byte at a time.
//   clk      system clock
//   load     capture data this cycle
//   data     CHANNELS x 16-bit samples, channel n at [16n+15:16n]
//   sel      {channel, byte}; byte 0 is the low byte
//   rd_byte  selected byte of the held set
module pcm_snapshot
    import pcm_frame_scheduler_pkg::*;
#(
    parameter  int unsigned CHANNELS = 2,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      load,
    input  logic [PCM_W*CHANNELS-1:0] data,
    input  logic [CH_W:0]             sel,
    output logic [7:0]                rd_byte
);

    logic [PCM_W*CHANNELS-1:0] snap;

    always_ff @(posedge clk) begin
        if (load) begin
            snap <= data;
        end
    end

    // The packed layout makes {channel, byte} a direct byte index.
    always_comb begin
        rd_byte = snap[32'(sel) * 8 +: 8];
    end

endmodule

// File: rtl/pcm_frame_scheduler.sv
// Sequences PCM sample sets into one half of a ping-pong BRAM and hands full frames, stamped
// with a sequence number, to the Ethernet transmitter while the other half fills.
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   pcm_frame_scheduler_if.master: PCM input, BRAM write port, transmitter handoff,
//         frame_len, overrun_cnt and sample_miss status
module pcm_frame_scheduler
    import pcm_frame_scheduler_pkg::*;
#(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned SAMPLES   = 64,
    parameter int unsigned HDR_BYTES = 14,
    parameter int unsigned ADDR_W    = 10
) (
    input logic                    clk,
    input logic                    rst,
    pcm_frame_scheduler_if.master  bus
);

    localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned SLOT_W    = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int unsigned OFF_W     = ADDR_W - 1;
    localparam int unsigned FRAME_LEN = HDR_BYTES + 2 + 2 * CHANNELS * SAMPLES;

    if (FRAME_LEN > (32'd1 << OFF_W)) begin : g_len_check
        $error("pcm_frame_scheduler: frame of %0d bytes does not fit a %0d-byte bank",
               FRAME_LEN, 32'd1 << OFF_W);
    end

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_chan_check
        $error("pcm_frame_scheduler: CHANNELS must be 1..16, got %0d", CHANNELS);
    end

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [SLOT_W-1:0]   slot;
    logic [SEQ_W-1:0]    seq;
    logic                fill_bank;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [7:0]          wr_data;
    logic                eth_start;
    logic                eth_bank;
    logic [7:0]          overrun_cnt;
    logic                sample_miss;

    logic                snap_load;
    logic                hi_byte;
    logic [CH_W:0]       snap_sel;
    logic [7:0]          snap_byte;
    logic [ADDR_W-1:0]   payload_addr;

    always_comb begin
        snap_load    = (state == StIdle) && bus.pcm_stb;
        hi_byte      = (state == StWrHi);
        snap_sel     = {ch, hi_byte};
        payload_addr = {fill_bank,
                        OFF_W'(payload_off(HDR_BYTES, CHANNELS, 32'(slot), 32'(ch),
                                           32'(hi_byte)))};
    end

    pcm_snapshot #(
        .CHANNELS (CHANNELS)
    ) u_snapshot (
        .clk     (clk),
        .load    (snap_load),
        .data    (bus.pcm_data),
        .sel     (snap_sel),
        .rd_byte (snap_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            ch          <= '0;
            slot        <= '0;
            seq         <= '0;
            fill_bank   <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            eth_start   <= 1'b0;
            eth_bank    <= 1'b1;
            overrun_cnt <= '0;
            sample_miss <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            eth_start <= 1'b0;

            // The strobe is only sampled in idle; anywhere else it is lost.
            if (bus.pcm_stb && state != StIdle) begin
                sample_miss <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (bus.pcm_stb) begin
                        ch    <= '0;
                        state <= StWrLo;
                    end
                end
                StWrLo: begin
                    wr_en   <= 1'b1;
                    wr_addr <= payload_addr;
                    wr_data <= snap_byte;
                    state   <= StWrHi;
                end
                StWrHi: begin
                    wr_en   <= 1'b1;
                    wr_addr <= payload_addr;
                    wr_data <= snap_byte;
                    if (ch == CH_W'(CHANNELS - 1)) begin
                        state <= StSlot;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= StWrLo;
                    end
                end
                StSlot: begin
                    if (slot == SLOT_W'(SAMPLES - 1)) begin
                        slot  <= '0;
                        state <= StSeqLo;
                    end else begin
                        slot  <= slot + 1'b1;
                        state <= StIdle;
                    end
                end
                StSeqLo: begin
                    wr_en   <= 1'b1;
                    wr_addr <= {fill_bank, OFF_W'(HDR_BYTES)};
                    wr_data <= seq[7:0];
                    state   <= StSeqHi;
                end
                StSeqHi: begin
                    wr_en   <= 1'b1;
                    wr_addr <= {fill_bank, OFF_W'(HDR_BYTES + 1)};
                    wr_data <= seq[15:8];
                    state   <= StHand;
                end
                StHand: begin
                    seq <= seq + 1'b1;
                    if (!bus.eth_busy) begin
                        eth_start <= 1'b1;
                        eth_bank  <= fill_bank;
                        fill_bank <= ~fill_bank;
                    end else if (overrun_cnt != 8'hFF) begin
                        // Busy transmitter: the frame is dropped and this bank refilled.
                        overrun_cnt <= overrun_cnt + 1'b1;
                    end
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.bram_wr_en   = wr_en;
    assign bus.bram_wr_addr = wr_addr;
    assign bus.bram_wr_data = wr_data;
    assign bus.eth_start    = eth_start;
    assign bus.eth_bank     = eth_bank;
    assign bus.frame_len    = ADDR_W'(FRAME_LEN);
    assign bus.overrun_cnt  = overrun_cnt;
    assign bus.sample_miss  = sample_miss;

endmodule

// File: tb/tb_pcm_frame_scheduler.sv
// Scoreboard bench for pcm_frame_scheduler with CHANNELS=2, SAMPLES=2.
module tb_pcm_frame_scheduler;

    localparam int unsigned CHANNELS  = 2;
    localparam int unsigned SAMPLES   = 2;
    localparam int unsigned HDR_BYTES = 14;
    localparam int unsigned ADDR_W    = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pcm_frame_scheduler_if #(.CHANNELS(CHANNELS), .ADDR_W(ADDR_W)) bus ();

    pcm_frame_scheduler #(
        .CHANNELS  (CHANNELS),
        .SAMPLES   (SAMPLES),
        .HDR_BYTES (HDR_BYTES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int errors = 0;

    // {bank, offset[8:0], data}
    logic [17:0] exp_wr[$];
    logic        exp_st[$];

    // Reference model state
    logic        m_fill;
    int          m_slot;
    logic [15:0] m_seq;
    int          m_ovr;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fill = 1'b0;
        m_slot = 0;
        m_seq  = 16'h0000;
        m_ovr  = 0;
    endtask

    task automatic push_slot(input logic [15:0] d0, input logic [15:0] d1);
        logic [8:0] off;
        off = 9'(HDR_BYTES + 2 + 2 * CHANNELS * m_slot);
        exp_wr.push_back({m_fill, off,         d0[7:0]});
        exp_wr.push_back({m_fill, off + 9'd1,  d0[15:8]});
        exp_wr.push_back({m_fill, off + 9'd2,  d1[7:0]});
        exp_wr.push_back({m_fill, off + 9'd3,  d1[15:8]});
        m_slot++;
        if (m_slot == SAMPLES) begin
            m_slot = 0;
            exp_wr.push_back({m_fill, 9'(HDR_BYTES),     m_seq[7:0]});
            exp_wr.push_back({m_fill, 9'(HDR_BYTES + 1), m_seq[15:8]});
            m_seq++;
            if (!bus.eth_busy) begin
                exp_st.push_back(m_fill);
                m_fill = ~m_fill;
            end else if (m_ovr < 255) begin
                m_ovr++;
            end
        end
    endtask

    task automatic strobe(input logic [15:0] d0, input logic [15:0] d1);
        @(posedge clk);
        #1;
        bus.pcm_stb  = 1'b1;
        bus.pcm_data = {d1, d0};
        @(posedge clk);
        #1;
        bus.pcm_stb  = 1'b0;
    endtask

    task automatic send_slot(input logic [15:0] d0, input logic [15:0] d1);
        push_slot(d0, d1);
        strobe(d0, d1);
        repeat (9) @(posedge clk);
    endtask

    // Second strobe lands while the scheduler is in WR_HI of the first channel.
    task automatic send_slot_with_miss(input logic [15:0] d0, input logic [15:0] d1);
        push_slot(d0, d1);
        strobe(d0, d1);
        @(posedge clk);
        #1;
        bus.pcm_stb  = 1'b1;
        bus.pcm_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.pcm_stb  = 1'b0;
        repeat (9) @(posedge clk);
    endtask

    task automatic send_frame(input logic busy, input logic [15:0] seed);
        bus.eth_busy = busy;
        for (int s = 0; s < SAMPLES; s++) begin
            send_slot(seed + 16'(s * 16'h0111), ~seed ^ 16'(s * 16'h2020));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: every write and every start pulse is matched against the scoreboard.
    always @(negedge clk) begin
        logic [17:0] e;
        logic        eb;
        if (bus.bram_wr_en === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL bram_write: got addr %0d data 0x%02h, expected no write",
                         bus.bram_wr_addr, bus.bram_wr_data);
            end else begin
                e = exp_wr.pop_front();
                if ({bus.bram_wr_addr, bus.bram_wr_data} !== e) begin
                    errors++;
                    $display("FAIL bram_write: got addr %0d data 0x%02h, expected addr %0d data 0x%02h",
                             bus.bram_wr_addr, bus.bram_wr_data, e[17:8], e[7:0]);
                end
            end
        end
        if (bus.eth_start === 1'b1) begin
            checks++;
            if (exp_st.size() == 0) begin
                errors++;
                $display("FAIL eth_start: got pulse with bank %0d, expected no pulse", bus.eth_bank);
            end else begin
                eb = exp_st.pop_front();
                if (bus.eth_bank !== eb) begin
                    errors++;
                    $display("FAIL eth_start_bank: got bank %0d, expected bank %0d", bus.eth_bank, eb);
                end
            end
        end
    end

    initial begin
        bus.pcm_stb  = 1'b0;
        bus.pcm_data = '0;
        bus.eth_busy = 1'b0;
        model_reset();

        // Reset values
        do_reset();
        check("reset_wr_en",       int'(bus.bram_wr_en),  0);
        check("reset_eth_start",   int'(bus.eth_start),   0);
        check("reset_eth_bank",    int'(bus.eth_bank),    1);
        check("reset_overrun_cnt", int'(bus.overrun_cnt), 0);
        check("reset_sample_miss", int'(bus.sample_miss), 0);
        check("frame_len",         int'(bus.frame_len),   24);

        // Frame 0 to bank 0 (first slot 0x1234/0xABCD), handed off; then a dropped frame in
        // bank 1, then bank 1 refilled and handed off.
        bus.eth_busy = 1'b0;
        send_slot(16'h1234, 16'hABCD);
        send_slot(16'h5678, 16'h9ABC);
        check("handoff_eth_bank", int'(bus.eth_bank), 0);
        send_frame(1'b1, 16'h0F0F);
        check("overrun_after_drop", int'(bus.overrun_cnt), 1);
        send_frame(1'b0, 16'h3C3C);
        check("eth_bank_second", int'(bus.eth_bank), 1);
        check("no_miss_yet",     int'(bus.sample_miss), 0);

        // Busy at handoff straight after reset: bank 0 reused, seq 0x0001 next
        do_reset();
        send_frame(1'b1, 16'h1111);
        check("overrun_one", int'(bus.overrun_cnt), 1);
        send_frame(1'b0, 16'h2222);
        check("eth_bank_bank0", int'(bus.eth_bank), 0);

        // Strobe while busy is dropped and flagged; frame still needs two accepted slots
        send_slot_with_miss(16'h4444, 16'h5555);
        check("sample_miss_set", int'(bus.sample_miss), 1);
        send_slot(16'h6666, 16'h7777);
        check("sample_miss_sticky", int'(bus.sample_miss), 1);

        // Reset during WR_HI of slot 1 abandons the frame
        do_reset();
        check("miss_cleared", int'(bus.sample_miss), 0);
        bus.eth_busy = 1'b0;
        send_slot(16'h8888, 16'h9999);
        exp_wr.push_back({m_fill, 9'(HDR_BYTES + 2 + 2 * CHANNELS), 8'hBB});
        strobe(16'hAABB, 16'hCCDD);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_wr_en",     int'(bus.bram_wr_en), 0);
        check("midreset_eth_start", int'(bus.eth_start),  0);
        rst = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        send_frame(1'b0, 16'hE001);

        // Long busy run: overrun saturates, seq keeps counting
        for (int f = 0; f < 300; f++) begin
            send_frame(1'b1, 16'(f * 16'h0103));
        end
        check("overrun_saturated", int'(bus.overrun_cnt), 255);
        check("model_seq_300", int'(m_seq), 301);

        repeat (10) @(posedge clk);
        check("writes_drained", exp_wr.size(), 0);
        check("starts_drained", exp_st.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
